mig_ui_responder: RTL
=====================

MIG_UI_RESPONDER -- requirements
Module: mig_ui_responder

Interface
REQ-001 SHALL have parameter addr_width, default 28, MIG app address width.
REQ-002 SHALL have parameter data_width, default 256, UI data beat width; mask width = data_width/8.
REQ-003 SHALL have parameter mem_depth_log2, default 10, log2 of model memory depth in beats.
REQ-004 SHALL have parameter init_cycles, default 16, cycles from reset release to mig_init_done.
REQ-005 SHALL have parameter read_latency, default 4, execute-to-return delay in cycles; legal range 2..16.
REQ-006 SHALL have parameter fifo_depth, default 4, depth of the command queue and the write-data queue.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port mig_init_done, output, 1, calibration-complete indication.
REQ-010 SHALL have port mig_af_rdy, output, 1, command queue can accept.
REQ-011 SHALL have ports mig_af_wr_en (input, 1), mig_af_addr (input, addr_width), mig_af_cmd (input, 3), command push.
REQ-012 SHALL have port mig_wdf_rdy, output, 1, write-data queue can accept.
REQ-013 SHALL have ports mig_wdf_wr_en (input, 1), mig_wdf_data (input, data_width), mig_wdf_last (input, 1), mig_wdf_mask (input, data_width/8), write-data push.
REQ-014 SHALL have ports mig_read_data_valid (output, 1), mig_read_data_last (output, 1), mig_read_data (output, data_width), read return.
REQ-015 SHALL have port protocol_error, output, 1, sticky error flag.

Function
REQ-016 SHALL count init_cycles cycles after reset deasserts, then hold mig_init_done = 1 until next reset.
REQ-017 SHALL drive mig_af_rdy = init_done AND command-queue count < fifo_depth, from registered count only (no same-cycle pop bypass).
REQ-018 SHALL drive mig_wdf_rdy = init_done AND write-queue count < fifo_depth, registered count only.
REQ-019 SHALL push a command when mig_af_wr_en AND mig_af_rdy; push with mig_af_rdy = 0 is dropped and sets protocol_error.
REQ-020 SHALL push write data when mig_wdf_wr_en AND mig_wdf_rdy; push with mig_wdf_rdy = 0 is dropped and sets protocol_error.
REQ-021 SHALL set protocol_error on a write-data push with mig_wdf_last = 0 (one UI beat per command, BL8, 4:1); data still queued.
REQ-022 SHALL accept mig_af_cmd 3'b000 (write) and 3'b001 (read); any other value is pushed, discarded at execution, and sets protocol_error.
REQ-023 SHALL map beat index = mig_af_addr[mem_depth_log2+2 : 3] (address in 8-column units), wrapping modulo 2^mem_depth_log2.
REQ-024 SHALL execute at most one command per cycle, strictly in queue order.
REQ-025 SHALL execute a queued write only when the write-data queue is non-empty, popping both in the same cycle; head write with empty data queue stalls all later commands.
REQ-026 SHALL write memory per byte: byte i updated iff mig_wdf_mask[i] = 0.
REQ-027 SHALL execute a read unconditionally at queue head; memory read in the execute cycle observes all earlier-executed writes.
REQ-028 SHALL assert mig_read_data_valid = mig_read_data_last = 1 for exactly one cycle, read_latency cycles after read execution, with the memory word; otherwise both 0.
REQ-029 SHALL hold mig_read_data at its last returned value when valid = 0.
REQ-030 SHALL allow simultaneous push and pop on each queue in one cycle; count unchanged.
REQ-031 SHALL support a read executed every cycle; return pipeline has no backpressure.

Reset
REQ-032 SHALL on reset: mig_init_done = 0, mig_af_rdy = 0, mig_wdf_rdy = 0, mig_read_data_valid = 0, mig_read_data_last = 0, mig_read_data = 0, protocol_error = 0, init counter restart.
REQ-033 SHALL on reset mid-operation flush both queues and the return pipeline (in-flight reads never return); memory contents not cleared.

Verification
REQ-034 Reset then idle -> mig_init_done rises exactly 16 cycles after reset release; af_rdy/wdf_rdy rise same cycle.
REQ-035 Write cmd addr 0x08, data 0xA5..A5, mask 0, then read addr 0x08 -> valid/last pulse 4 cycles after read execution, data 0xA5..A5.
REQ-036 Write cmd addr 0x10 with no wdf data for 10 cycles, read addr 0x00 queued behind -> no read return until data pushed; then write executes, read returns 4 cycles later.
REQ-037 Five commands pushed back-to-back, no execution possible -> af_rdy = 0 after 4th; 5th push sets protocol_error, cmd dropped.
REQ-038 Mask 0xFFFF_FFFE write of 0x11..11 over 0x00 at addr 0 -> readback byte0 = 0x11, other bytes 0x00; addr 0x2000 (wrap, depth 1024) aliases addr 0.
REQ-039 Reset asserted 2 cycles after a read executes -> no valid pulse ever appears; memory readback after re-init unchanged.

Source files
------------

// File: rtl/mig_ui_responder_if.sv
// MIG user-interface bundle between a memory client (master) and the responder model (slave).
// Latency: none, wires only.
// Backpressure: mig_af_rdy / mig_wdf_rdy gate pushes; the read return path has no backpressure.
interface mig_ui_responder_if #(
   parameter int addr_width = 28,
   parameter int data_width = 256
);
   logic                      mig_init_done;
   logic                      mig_af_rdy;
   logic                      mig_af_wr_en;
   logic [addr_width-1:0]     mig_af_addr;
   logic [2:0]                mig_af_cmd;
   logic                      mig_wdf_rdy;
   logic                      mig_wdf_wr_en;
   logic [data_width-1:0]     mig_wdf_data;
   logic                      mig_wdf_last;
   logic [data_width/8-1:0]   mig_wdf_mask;
   logic                      mig_read_data_valid;
   logic                      mig_read_data_last;
   logic [data_width-1:0]     mig_read_data;
   logic                      protocol_error;

   modport master (
      input  mig_init_done, mig_af_rdy, mig_wdf_rdy,
             mig_read_data_valid, mig_read_data_last, mig_read_data, protocol_error,
      output mig_af_wr_en, mig_af_addr, mig_af_cmd,
             mig_wdf_wr_en, mig_wdf_data, mig_wdf_last, mig_wdf_mask
   );

   modport slave (
      output mig_init_done, mig_af_rdy, mig_wdf_rdy,
             mig_read_data_valid, mig_read_data_last, mig_read_data, protocol_error,
      input  mig_af_wr_en, mig_af_addr, mig_af_cmd,
             mig_wdf_wr_en, mig_wdf_data, mig_wdf_last, mig_wdf_mask
   );
endinterface

// File: rtl/mig_ui_responder.sv
// Behavioural MIG UI responder: command + write-data queues, byte-masked beat memory, fixed-latency reads.
// Latency: a read returns read_latency cycles after it executes at the command-queue head.
// Backpressure: af/wdf ready from registered queue counts; pushes while not ready are dropped and flagged.
module mig_ui_responder #(
   parameter int addr_width     = 28,
   parameter int data_width     = 256,
   parameter int mem_depth_log2 = 10,
   parameter int init_cycles    = 16,
   parameter int read_latency   = 4,
   parameter int fifo_depth     = 4
) (
   input  logic              clk,
   input  logic              reset,
   mig_ui_responder_if.slave ui
);
   localparam int mask_width = data_width / 8;
   localparam int ptr_width  = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
   localparam int cnt_width  = $clog2(fifo_depth + 1);
   localparam int init_width = $clog2(init_cycles + 2);
   localparam int mem_depth  = 1 << mem_depth_log2;

   typedef logic [mem_depth_log2-1:0] idx_t;
   typedef logic [ptr_width-1:0]      ptr_t;
   typedef logic [cnt_width-1:0]      cnt_t;

   // calibration model
   logic [init_width-1:0] init_cnt_q;
   logic                  init_done_q;

   // command queue (stores the beat index, already wrapped to memory depth)
   idx_t       cmd_idx_q [fifo_depth];
   logic [2:0] cmd_op_q  [fifo_depth];
   ptr_t       cmd_wp_q, cmd_rp_q, cmd_wp_d, cmd_rp_d;
   cnt_t       cmd_cnt_q, cmd_cnt_d;

   // write-data queue
   logic [data_width-1:0] wd_data_q [fifo_depth];
   logic [mask_width-1:0] wd_mask_q [fifo_depth];
   ptr_t                  wd_wp_q, wd_rp_q, wd_wp_d, wd_rp_d;
   cnt_t                  wd_cnt_q, wd_cnt_d;

   logic [data_width-1:0] mem_q [mem_depth];

   // read return pipeline; the last data stage only loads on a returning beat so it holds
   logic [read_latency-1:0] rv_q;
   logic [data_width-1:0]   rd_pipe_q [read_latency];

   logic err_q, err_d;

   logic af_rdy, wdf_rdy;
   logic cmd_push, cmd_drop, wd_push, wd_drop;
   logic head_vld, exec_wr, exec_rd, exec_bad, cmd_pop;
   idx_t head_idx;
   logic [2:0] head_op;
   logic unused_addr;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(fifo_depth - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // only addr[mem_depth_log2+2:3] selects a beat; the rest is deliberately ignored
   assign unused_addr = ^ui.mig_af_addr;

   assign af_rdy   = init_done_q && (cmd_cnt_q < cnt_t'(fifo_depth));
   assign wdf_rdy  = init_done_q && (wd_cnt_q  < cnt_t'(fifo_depth));
   assign cmd_push = ui.mig_af_wr_en  &  af_rdy;
   assign cmd_drop = ui.mig_af_wr_en  & ~af_rdy;
   assign wd_push  = ui.mig_wdf_wr_en &  wdf_rdy;
   assign wd_drop  = ui.mig_wdf_wr_en & ~wdf_rdy;

   assign head_vld = (cmd_cnt_q != '0);
   assign head_idx = cmd_idx_q[cmd_rp_q];
   assign head_op  = cmd_op_q[cmd_rp_q];
   // a head write waits for its data beat and blocks everything behind it
   assign exec_wr  = head_vld && (head_op == 3'b000) && (wd_cnt_q != '0);
   assign exec_rd  = head_vld && (head_op == 3'b001);
   assign exec_bad = head_vld && (head_op != 3'b000) && (head_op != 3'b001);
   assign cmd_pop  = exec_wr || exec_rd || exec_bad;

   // queue pointer/count and sticky error next-state
   always_comb begin
      cmd_wp_d  = cmd_push ? ptr_inc(cmd_wp_q) : cmd_wp_q;
      cmd_rp_d  = cmd_pop  ? ptr_inc(cmd_rp_q) : cmd_rp_q;
      wd_wp_d   = wd_push  ? ptr_inc(wd_wp_q)  : wd_wp_q;
      wd_rp_d   = exec_wr  ? ptr_inc(wd_rp_q)  : wd_rp_q;
      cmd_cnt_d = cmd_cnt_q;
      wd_cnt_d  = wd_cnt_q;
      if (cmd_push && !cmd_pop)      cmd_cnt_d = cmd_cnt_q + cnt_t'(1);
      else if (!cmd_push && cmd_pop) cmd_cnt_d = cmd_cnt_q - cnt_t'(1);
      if (wd_push && !exec_wr)       wd_cnt_d  = wd_cnt_q + cnt_t'(1);
      else if (!wd_push && exec_wr)  wd_cnt_d  = wd_cnt_q - cnt_t'(1);
      err_d = err_q | cmd_drop | wd_drop | (wd_push & ~ui.mig_wdf_last) | exec_bad;
   end

   // control state: init counter, queue pointers/counts, error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
         cmd_wp_q    <= '0;
         cmd_rp_q    <= '0;
         cmd_cnt_q   <= '0;
         wd_wp_q     <= '0;
         wd_rp_q     <= '0;
         wd_cnt_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         if (!init_done_q) begin
            init_cnt_q <= init_cnt_q + 1'b1;
            if (init_cnt_q == init_width'(init_cycles - 1)) init_done_q <= 1'b1;
         end
         cmd_wp_q  <= cmd_wp_d;
         cmd_rp_q  <= cmd_rp_d;
         cmd_cnt_q <= cmd_cnt_d;
         wd_wp_q   <= wd_wp_d;
         wd_rp_q   <= wd_rp_d;
         wd_cnt_q  <= wd_cnt_d;
         err_q     <= err_d;
      end
   end

   // queue storage, written on accepted pushes only
   always_ff @(posedge clk) begin
      if (cmd_push) begin
         cmd_idx_q[cmd_wp_q] <= ui.mig_af_addr[mem_depth_log2+2:3];
         cmd_op_q[cmd_wp_q]  <= ui.mig_af_cmd;
      end
      if (wd_push) begin
         wd_data_q[wd_wp_q] <= ui.mig_wdf_data;
         wd_mask_q[wd_wp_q] <= ui.mig_wdf_mask;
      end
   end

   // byte-masked memory write; contents survive reset
   always_ff @(posedge clk) begin
      if (exec_wr && !reset) begin
         for (int i = 0; i < mask_width; i++) begin
            if (!wd_mask_q[wd_rp_q][i])
               mem_q[head_idx][i*8 +: 8] <= wd_data_q[wd_rp_q][i*8 +: 8];
         end
      end
   end

   // read return pipeline, flushed by reset so in-flight reads are lost
   always_ff @(posedge clk) begin
      if (reset) begin
         rv_q <= '0;
         for (int i = 0; i < read_latency; i++) rd_pipe_q[i] <= '0;
      end else begin
         rv_q <= {rv_q[read_latency-2:0], exec_rd};
         if (exec_rd) rd_pipe_q[0] <= mem_q[head_idx];
         for (int i = 1; i < read_latency - 1; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
         if (rv_q[read_latency-2]) rd_pipe_q[read_latency-1] <= rd_pipe_q[read_latency-2];
      end
   end

   assign ui.mig_init_done       = init_done_q;
   assign ui.mig_af_rdy          = af_rdy;
   assign ui.mig_wdf_rdy         = wdf_rdy;
   assign ui.mig_read_data_valid = rv_q[read_latency-1];
   assign ui.mig_read_data_last  = rv_q[read_latency-1];
   assign ui.mig_read_data       = rd_pipe_q[read_latency-1];
   assign ui.protocol_error      = err_q;
endmodule
